// File: rtl/rename_map_table_ckpt.sv
// Speculative + committed rename map with a circular pool of branch checkpoints.
// Reads are combinational with intra-group bypass; ren_stall_o holds a group that needs a checkpoint when none is free.
module rename_map_table_ckpt #(
    parameter int RW       = 2,
    parameter int CW       = 2,
    parameter int ARCH_NUM = 34,
    parameter int PRF_W    = 6,
    parameter int CKPT_NUM = 4,
    localparam int CK_W    = $clog2(CKPT_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RW-1:0]       ren_valid_i,
    input  logic [RW-1:0]       ren_wen_i,
    input  logic [RW*6-1:0]     ren_ars1_i,
    input  logic [RW*6-1:0]     ren_ars2_i,
    input  logic [RW*6-1:0]     ren_ard_i,
    input  logic [RW*PRF_W-1:0] ren_prd_new_i,
    output logic [RW*PRF_W-1:0] ren_prs1_o,
    output logic [RW*PRF_W-1:0] ren_prs2_o,
    output logic [RW*PRF_W-1:0] ren_prd_stale_o,
    input  logic                ckpt_req_i,
    output logic                ckpt_ready_o,
    output logic [CK_W-1:0]     ckpt_id_o,
    output logic                ren_stall_o,
    input  logic                ckpt_release_i,
    input  logic                ckpt_restore_i,
    input  logic [CK_W-1:0]     ckpt_restore_id_i,
    input  logic                recover_i,
    input  logic [CW-1:0]       cmt_valid_i,
    input  logic [CW*6-1:0]     cmt_ard_i,
    input  logic [CW*PRF_W-1:0] cmt_prd_i
);

    typedef logic [PRF_W-1:0] map_t [ARCH_NUM];

    localparam logic [5:0]    ARCH_LIM = 6'(ARCH_NUM);
    localparam logic [CK_W:0] FULL     = (CK_W+1)'(CKPT_NUM);

    map_t spec_q, spec_d;
    map_t cmt_q, cmt_d;
    map_t grp_map;
    map_t ckpt_q [CKPT_NUM];

    logic [CK_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CK_W:0]   count_q, count_d, count_base;
    logic [CK_W-1:0] rst_cnt;
    logic [RW-1:0]   wr_ok;
    logic [CW-1:0]   cmt_ok;
    logic            grp_go, req_go, rel_go;

    always_comb begin
        for (int i = 0; i < RW; i++) begin
            wr_ok[i] = ren_valid_i[i] & ren_wen_i[i] & (ren_ard_i[6*i+:6] != 6'd0)
                     & (ren_ard_i[6*i+:6] < ARCH_LIM);
        end
        for (int i = 0; i < CW; i++) begin
            cmt_ok[i] = cmt_valid_i[i] & (cmt_ard_i[6*i+:6] != 6'd0)
                      & (cmt_ard_i[6*i+:6] < ARCH_LIM);
        end
    end

    // Spec map lookup, overridden by the youngest older lane of this group writing the same reg.
    function automatic logic [PRF_W-1:0] rd(input logic [5:0] a, input int lane);
        logic [PRF_W-1:0] v;
        v = (a != 6'd0 && a < ARCH_LIM) ? spec_q[a] : '0;
        for (int i = 0; i < RW; i++) begin
            if (i < lane && wr_ok[i] && ren_ard_i[6*i+:6] == a) begin
                v = ren_prd_new_i[PRF_W*i+:PRF_W];
            end
        end
        return v;
    endfunction

    always_comb begin
        for (int j = 0; j < RW; j++) begin
            ren_prs1_o[PRF_W*j+:PRF_W]      = rd(ren_ars1_i[6*j+:6], j);
            ren_prs2_o[PRF_W*j+:PRF_W]      = rd(ren_ars2_i[6*j+:6], j);
            ren_prd_stale_o[PRF_W*j+:PRF_W] = rd(ren_ard_i[6*j+:6], j);
        end
    end

    always_comb begin
        grp_map = spec_q;
        for (int i = 0; i < RW; i++) begin
            if (wr_ok[i]) grp_map[ren_ard_i[6*i+:6]] = ren_prd_new_i[PRF_W*i+:PRF_W];
        end
        cmt_d = cmt_q;
        for (int i = 0; i < CW; i++) begin
            if (cmt_ok[i]) cmt_d[cmt_ard_i[6*i+:6]] = cmt_prd_i[PRF_W*i+:PRF_W];
        end
    end

    assign ckpt_ready_o = (count_q != FULL);
    assign ckpt_id_o    = tail_q;
    assign ren_stall_o  = ckpt_req_i & ~ckpt_ready_o;

    assign grp_go = ~recover_i & ~ckpt_restore_i & ~ren_stall_o;
    assign req_go = grp_go & ckpt_req_i;
    assign rel_go = ckpt_release_i & (count_q != '0) & ~recover_i;

    // Restored slot stays live: live set becomes [head, id]; a zero difference wraps to a full pool.
    assign rst_cnt = ckpt_restore_id_i - head_q + CK_W'(1);

    always_comb begin
        spec_d     = spec_q;
        head_d     = head_q + CK_W'(rel_go);
        tail_d     = tail_q + CK_W'(req_go);
        count_base = count_q + (CK_W+1)'(req_go);
        if (recover_i) begin
            spec_d     = cmt_d;
            head_d     = '0;
            tail_d     = '0;
            count_base = '0;
        end else if (ckpt_restore_i) begin
            spec_d     = ckpt_q[ckpt_restore_id_i];
            tail_d     = ckpt_restore_id_i + CK_W'(1);
            count_base = (rst_cnt == '0) ? FULL : {1'b0, rst_cnt};
        end else if (grp_go) begin
            spec_d = grp_map;
        end
        count_d = count_base - (CK_W+1)'(rel_go);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_NUM; i++) begin
                spec_q[i] <= PRF_W'(i);
                cmt_q[i]  <= PRF_W'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            spec_q  <= spec_d;
            cmt_q   <= cmt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_go) ckpt_q[tail_q] <= grp_map;
    end

endmodule
